// File: rtl/cam_pkg.sv
// Shared types and constants for the CAM transmit scheduler.
package cam_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned ID_W   = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        WAIT = 2'd2
    } cam_tx_state_t;

    localparam logic [15:0]     CAM_HB_TAG = 16'hC0DE;
    localparam logic [ID_W-1:0] CAM_HB_ID  = 3'd7;

endpackage

// File: rtl/cam_rr_arbiter.sv
// Combinational requester selection: requester 0 has strict priority,
// requesters 1..NUM_REQ-1 are served round-robin after the pointer.
module cam_rr_arbiter
    import cam_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic [NUM_REQ-1:0] gnt_oh_c,
    output logic [ID_W-1:0]    gnt_idx_c,
    output logic               gnt_vld_c
);

    localparam int unsigned CW      = ID_W + 1;
    localparam int unsigned MAX_REQ = 1 << ID_W;

    logic [MAX_REQ-1:0] req_pad_c;
    logic [CW-1:0]      cand_c;

    assign req_pad_c = MAX_REQ'(req_i);

    // Candidates wrap within 1..NUM_REQ-1, starting one past the pointer
    always_comb begin
        gnt_idx_c = '0;
        gnt_vld_c = 1'b0;
        cand_c    = '0;
        if (req_i[0]) begin
            gnt_vld_c = 1'b1;
        end else begin
            for (int unsigned i = 0; i < NUM_REQ - 1; i++) begin
                cand_c = CW'(ptr_i) + CW'(i) + CW'(1);
                if (cand_c >= CW'(NUM_REQ)) begin
                    cand_c = cand_c - CW'(NUM_REQ - 1);
                end
                if (!gnt_vld_c && req_pad_c[cand_c[ID_W-1:0]]) begin
                    gnt_vld_c = 1'b1;
                    gnt_idx_c = cand_c[ID_W-1:0];
                end
            end
        end
    end

    assign gnt_oh_c = gnt_vld_c ? NUM_REQ'(MAX_REQ'(1) << gnt_idx_c) : '0;

endmodule

// File: rtl/cam_tx_scheduler.sv
// Arbitrates requester words onto a nibble serializer, one word per busy period.
// Optional idle heartbeat words are enabled by defining CAM_TX_HEARTBEAT_EN.
module cam_tx_scheduler
    import cam_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned HB_INTERVAL = 50000,
    parameter int unsigned WD_LIMIT    = 1023
) (
    input  logic                      clk_i,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ*WORD_W-1:0] data_i,
    output logic [NUM_REQ-1:0]        ack_o,
    output logic                      ser_wr_o,
    output logic [WORD_W-1:0]         ser_data_o,
    input  logic                      ser_busy_i,
    output logic [ID_W-1:0]           grant_id_o,
    output logic                      wd_err_o
);

    localparam int unsigned WD_W = $clog2(WD_LIMIT + 1);

    if (NUM_REQ < 2 || NUM_REQ > 8 || HB_INTERVAL == 0 || WD_LIMIT == 0) begin : g_param_check
        $error("cam_tx_scheduler: illegal parameter value");
    end

    cam_tx_state_t      state_q, state_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic               ser_wr_q, ser_wr_d;
    logic [WORD_W-1:0]  ser_data_q, ser_data_d;
    logic [ID_W-1:0]    grant_id_q, grant_id_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [WD_W-1:0]    wd_cnt_q, wd_cnt_d;
    logic               wd_err_q, wd_err_d;

    logic [NUM_REQ-1:0] gnt_oh_c;
    logic [ID_W-1:0]    gnt_idx_c;
    logic               gnt_vld_c;
    logic [WORD_W-1:0]  req_word_c;
    logic [WORD_W-1:0]  hb_word_c;
    logic               hb_fire_c;
    logic               issue_c;

    cam_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req_i     (req_i),
        .ptr_i     (ptr_q),
        .gnt_oh_c  (gnt_oh_c),
        .gnt_idx_c (gnt_idx_c),
        .gnt_vld_c (gnt_vld_c)
    );

    always_comb begin
        req_word_c = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (gnt_oh_c[k]) begin
                req_word_c = data_i[k*WORD_W +: WORD_W];
            end
        end
    end

    assign issue_c = (state_q == IDLE) && !ser_busy_i && (gnt_vld_c || hb_fire_c);

`ifdef CAM_TX_HEARTBEAT_EN
    localparam int unsigned HB_W = $clog2(HB_INTERVAL + 1);

    logic [HB_W-1:0] hb_cnt_q, hb_cnt_d;
    logic [15:0]     seq_q, seq_d;
    logic            idle_free_c;

    assign idle_free_c = (state_q == IDLE) && !ser_busy_i;
    // A pending request always beats an expiring heartbeat
    assign hb_fire_c   = idle_free_c && (req_i == '0) && (hb_cnt_q == HB_W'(HB_INTERVAL - 1));
    assign hb_word_c   = {CAM_HB_TAG, seq_q};

    always_comb begin
        hb_cnt_d = hb_cnt_q;
        seq_d    = seq_q;
        if (issue_c || (req_i != '0)) begin
            hb_cnt_d = '0;
        end else if (idle_free_c) begin
            hb_cnt_d = hb_cnt_q + HB_W'(1);
        end
        if (hb_fire_c) begin
            seq_d = seq_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            hb_cnt_q <= '0;
            seq_q    <= '0;
        end else begin
            hb_cnt_q <= hb_cnt_d;
            seq_q    <= seq_d;
        end
    end
`else
    assign hb_fire_c = 1'b0;
    assign hb_word_c = '0;
`endif

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (issue_c) state_d = HOLD;
            HOLD:    state_d = WAIT;
            WAIT:    if (!ser_busy_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Issue bookkeeping and the busy watchdog
    always_comb begin
        ack_d      = '0;
        ser_wr_d   = 1'b0;
        ser_data_d = ser_data_q;
        grant_id_d = grant_id_q;
        ptr_d      = ptr_q;
        wd_cnt_d   = '0;
        wd_err_d   = wd_err_q;
        if (issue_c) begin
            ser_wr_d = 1'b1;
            if (gnt_vld_c) begin
                ack_d      = gnt_oh_c;
                ser_data_d = req_word_c;
                grant_id_d = gnt_idx_c;
                if (!gnt_oh_c[0]) begin
                    ptr_d = gnt_idx_c;
                end
            end else begin
                ser_data_d = hb_word_c;
                grant_id_d = CAM_HB_ID;
            end
        end
        // Flag shows in the (WD_LIMIT+1)th consecutive busy cycle of WAIT
        if ((state_q == WAIT) && ser_busy_i) begin
            wd_cnt_d = (wd_cnt_q == WD_W'(WD_LIMIT)) ? wd_cnt_q : wd_cnt_q + WD_W'(1);
            if (wd_cnt_q >= WD_W'(WD_LIMIT - 1)) begin
                wd_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            ack_q      <= '0;
            ser_wr_q   <= 1'b0;
            ser_data_q <= '0;
            grant_id_q <= '0;
            ptr_q      <= '0;
            wd_cnt_q   <= '0;
            wd_err_q   <= 1'b0;
        end else begin
            ack_q      <= ack_d;
            ser_wr_q   <= ser_wr_d;
            ser_data_q <= ser_data_d;
            grant_id_q <= grant_id_d;
            ptr_q      <= ptr_d;
            wd_cnt_q   <= wd_cnt_d;
            wd_err_q   <= wd_err_d;
        end
    end

    assign ack_o      = ack_q;
    assign ser_wr_o   = ser_wr_q;
    assign ser_data_o = ser_data_q;
    assign grant_id_o = grant_id_q;
    assign wd_err_o   = wd_err_q;

endmodule

// File: tb/tb_cam_tx_scheduler.sv
// Directed self-checking bench for cam_tx_scheduler.
module tb_cam_tx_scheduler;

    localparam int unsigned NUM_REQ     = 4;
    localparam int unsigned HB_INTERVAL = 8;
    localparam int unsigned WD_LIMIT    = 1023;

    logic         clk_i = 1'b0;
    logic         rst_n = 1'b0;
    logic [3:0]   req_i = '0;
    logic [127:0] data_i;
    logic [3:0]   ack_o;
    logic         ser_wr_o;
    logic [31:0]  ser_data_o;
    logic         ser_busy_i = 1'b0;
    logic [2:0]   grant_id_o;
    logic         wd_err_o;

    logic [31:0]  w [4];
    int           exp_id [4];
    int unsigned  n_assert = 0;
    int unsigned  n_fail   = 0;
    int unsigned  waited, wr_cnt, first_err;

    assign data_i = {w[3], w[2], w[1], w[0]};

    cam_tx_scheduler #(
        .NUM_REQ     (NUM_REQ),
        .HB_INTERVAL (HB_INTERVAL),
        .WD_LIMIT    (WD_LIMIT)
    ) dut (
        .clk_i      (clk_i),
        .rst_n      (rst_n),
        .req_i      (req_i),
        .data_i     (data_i),
        .ack_o      (ack_o),
        .ser_wr_o   (ser_wr_o),
        .ser_data_o (ser_data_o),
        .ser_busy_i (ser_busy_i),
        .grant_id_o (grant_id_o),
        .wd_err_o   (wd_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Returns at the negedge where ser_wr_o is seen, or after max_cyc cycles
    task automatic wait_wr(input string tag, input int unsigned max_cyc, output int unsigned cyc);
        cyc = 0;
        do begin
            @(negedge clk_i);
            cyc++;
        end while (!ser_wr_o && cyc < max_cyc);
        chk(tag, 32'(ser_wr_o), 32'd1);
    endtask

    task automatic busy_period(input string tag, input int unsigned n);
        int unsigned cnt;
        cnt = 0;
        ser_busy_i = 1'b1;
        repeat (n) begin
            @(negedge clk_i);
            if (ser_wr_o) cnt++;
        end
        ser_busy_i = 1'b0;
        chk(tag, cnt, 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        w[0] = 32'hA0A0_0000;
        w[1] = 32'h1234_5678;
        w[2] = 32'h2222_BBBB;
        w[3] = 32'h3333_CCCC;
        exp_id[0] = 1; exp_id[1] = 2; exp_id[2] = 3; exp_id[3] = 1;
        repeat (3) @(negedge clk_i);
        chk("rst_ack", 32'(ack_o), 32'd0);
        chk("rst_wr", 32'(ser_wr_o), 32'd0);
        chk("rst_data", ser_data_o, 32'd0);
        chk("rst_gid", 32'(grant_id_o), 32'd0);
        chk("rst_wd", 32'(wd_err_o), 32'd0);
        rst_n = 1'b1;

`ifdef CAM_TX_HEARTBEAT_EN
        wait_wr("hb0_wr", 20, waited);
        chk("hb0_delay", waited, 32'd8);
        chk("hb0_data", ser_data_o, 32'hC0DE_0000);
        chk("hb0_gid", 32'(grant_id_o), 32'd7);
        chk("hb0_ack", 32'(ack_o), 32'd0);
        wait_wr("hb1_wr", 20, waited);
        chk("hb1_delay", waited, 32'd10);
        chk("hb1_data", ser_data_o, 32'hC0DE_0001);
        chk("hb1_gid", 32'(grant_id_o), 32'd7);
        chk("hb1_ack", 32'(ack_o), 32'd0);
        // Raise req0 so it is sampled on the edge the heartbeat would fire
        repeat (9) @(negedge clk_i);
        req_i = 4'b0001;
        wait_wr("race_wr", 4, waited);
        chk("race_delay", waited, 32'd1);
        chk("race_gid", 32'(grant_id_o), 32'd0);
        chk("race_ack", 32'(ack_o), 32'd1);
        chk("race_data", ser_data_o, w[0]);
        req_i = '0;
        wait_wr("hb2_wr", 20, waited);
        chk("hb2_delay", waited, 32'd10);
        chk("hb2_data", ser_data_o, 32'hC0DE_0002);
        chk("hb2_gid", 32'(grant_id_o), 32'd7);
`else
        // Single request, issued one cycle after sampling
        @(negedge clk_i);
        req_i = 4'b0010;
        wait_wr("a_wr", 4, waited);
        chk("a_delay", waited, 32'd1);
        chk("a_ack", 32'(ack_o), 32'b0010);
        chk("a_data", ser_data_o, 32'h1234_5678);
        chk("a_gid", 32'(grant_id_o), 32'd1);
        req_i = '0;
        busy_period("a_busy_no_wr", 20);
        chk("a_data_hold", ser_data_o, 32'h1234_5678);
        chk("a_ack_low", 32'(ack_o), 32'd0);

        // Round robin from reset, then urgent requester
        do_reset();
        req_i = 4'b1110;
        for (int i = 0; i < 4; i++) begin
            wait_wr("rr_wr", 30, waited);
            chk("rr_gid", 32'(grant_id_o), 32'(exp_id[i]));
            chk("rr_ack", 32'(ack_o), 32'd1 << exp_id[i]);
            chk("rr_data", ser_data_o, w[exp_id[i]]);
            busy_period("rr_busy_no_wr", 20);
        end
        req_i = 4'b1111;
        wait_wr("urg_wr", 30, waited);
        chk("urg_gid", 32'(grant_id_o), 32'd0);
        chk("urg_ack", 32'(ack_o), 32'b0001);
        chk("urg_data", ser_data_o, w[0]);
        req_i = 4'b1110;
        busy_period("urg_busy_no_wr", 5);
        wait_wr("rr_after_urg_wr", 30, waited);
        chk("rr_after_urg_gid", 32'(grant_id_o), 32'd2);
        req_i = '0;
        busy_period("rr_end_busy", 3);

        // Watchdog: busy stuck high, a request posted meanwhile must wait
        @(negedge clk_i);
        req_i = 4'b0100;
        wait_wr("wd_wr", 10, waited);
        chk("wd_gid", 32'(grant_id_o), 32'd2);
        req_i = '0;
        ser_busy_i = 1'b1;
        first_err = 0;
        wr_cnt = 0;
        for (int unsigned k = 1; k <= 1100; k++) begin
            @(negedge clk_i);
            if (ser_wr_o) wr_cnt++;
            if (wd_err_o && first_err == 0) first_err = k;
            if (k == 500) req_i = 4'b0001;
        end
        chk("wd_first_cycle", first_err, WD_LIMIT + 1);
        chk("wd_no_second_wr", wr_cnt, 32'd0);
        ser_busy_i = 1'b0;
        wait_wr("wd_resume_wr", 10, waited);
        chk("wd_resume_gid", 32'(grant_id_o), 32'd0);
        req_i = '0;
        repeat (3) @(negedge clk_i);
        chk("wd_sticky", 32'(wd_err_o), 32'd1);
        do_reset();
        chk("wd_cleared", 32'(wd_err_o), 32'd0);

        // Reset asserted in HOLD clears strobes immediately, no replay
        @(negedge clk_i);
        req_i = 4'b0010;
        wait_wr("hold_wr", 4, waited);
        rst_n = 1'b0;
        #1;
        chk("hold_rst_wr", 32'(ser_wr_o), 32'd0);
        chk("hold_rst_ack", 32'(ack_o), 32'd0);
        req_i = '0;
        @(negedge clk_i);
        rst_n = 1'b1;
        wr_cnt = 0;
        repeat (5) begin
            @(negedge clk_i);
            if (ser_wr_o) wr_cnt++;
        end
        chk("no_replay", wr_cnt, 32'd0);
        req_i = 4'b1000;
        wait_wr("post_rst_wr", 4, waited);
        chk("post_rst_delay", waited, 32'd1);
        chk("post_rst_gid", 32'(grant_id_o), 32'd3);
        req_i = '0;

        // A request that drops while WAIT holds is lost
        ser_busy_i = 1'b1;
        repeat (3) @(negedge clk_i);
        req_i = 4'b0010;
        repeat (3) @(negedge clk_i);
        req_i = '0;
        repeat (2) @(negedge clk_i);
        ser_busy_i = 1'b0;
        wr_cnt = 0;
        repeat (6) begin
            @(negedge clk_i);
            if (ser_wr_o) wr_cnt++;
        end
        chk("lost_req", wr_cnt, 32'd0);
        chk("lost_gid", 32'(grant_id_o), 32'd3);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
